// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the posted-store buffer: store size
// encodings, data width and the packed layout of one buffered store.
package store_buffer_pkg;

  localparam int N     = 32;
  localparam int ST_AW = 32;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef struct packed {
    logic [ST_AW-3:0] addr;
    logic [N-1:0]     data;
    logic [3:0]       be;
  } stbuf_entry_t;

endpackage

// File: rtl/store_align.sv
// Combinational store aligner: turns size/address/right-justified data into
// a 32-bit lane with byte enables and flags misaligned or reserved sizes.
module store_align
  import store_buffer_pkg::*;
(
  input  logic [1:0]   i_size,
  input  logic [1:0]   i_addr_lo,
  input  logic [N-1:0] i_data,
  output logic [3:0]   o_be,
  output logic [N-1:0] o_lane,
  output logic         o_misaligned
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    o_be         = 4'b0000;
    o_lane       = '0;
    o_misaligned = 1'b0;
    case (i_size)
      SZ_B: begin
        o_be   = 4'b0001 << i_addr_lo;
        o_lane = {4{i_data[7:0]}};
      end
      SZ_H: begin
        o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_lane       = {2{i_data[15:0]}};
        o_misaligned = i_addr_lo[0];
      end
      SZ_W: begin
        o_be         = 4'b1111;
        o_lane       = i_data;
        o_misaligned = |i_addr_lo;
      end
      default: o_misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// In-order posted-store FIFO draining to data memory over dm_we/dm_ack.
// Define STBUF_FWD_EN to forward full-word stores to a matching load.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = ST_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          st_valid,
  input  logic [1:0]    st_size,
  input  logic [AW-1:0] st_addr,
  input  logic [N-1:0]  st_data,
  output logic          st_ready,
  output logic          st_err,
  output logic          dm_we,
  output logic [AW-3:0] dm_addr,
  output logic [N-1:0]  dm_d,
  output logic [3:0]    dm_be,
  input  logic          dm_ack,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_conflict,
  output logic          ld_hit,
  output logic [N-1:0]  ld_fwd,
  output logic          empty
);

  localparam int          PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          r_st_err;
  stbuf_entry_t  r_mem [DEPTH];

  logic [3:0]    w_be;
  logic [N-1:0]  w_lane;
  logic          w_misaligned;
  logic          w_push;
  logic          w_pop;
  logic          w_match;
  stbuf_entry_t  w_head;
  logic          w_unused_ld_lo;

  store_align u_align (
    .i_size       (st_size),
    .i_addr_lo    (st_addr[1:0]),
    .i_data       (st_data),
    .o_be         (w_be),
    .o_lane       (w_lane),
    .o_misaligned (w_misaligned)
  );

  assign st_ready = (r_count != FULL_CNT);
  assign empty    = (r_count == '0);
  assign st_err   = r_st_err;
  assign w_push   = st_valid && st_ready && !w_misaligned;
  assign w_pop    = dm_ack && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_st_err <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      r_st_err <= st_valid && st_ready && w_misaligned;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the entry array is deliberately not reset; an entry only matters
  // while r_count covers it, and every consumer is qualified by that.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{addr: st_addr[AW-1:2], data: w_lane, be: w_be};
    end
  end

  assign w_head  = r_mem[r_rd_ptr];
  assign dm_we   = !empty;
  assign dm_addr = empty ? '0 : w_head.addr;
  assign dm_d    = empty ? '0 : w_head.data;
  assign dm_be   = empty ? '0 : w_head.be;

  // Loads compare at word granularity, so the byte offset is not needed.
  assign w_unused_ld_lo = &{1'b0, ld_addr[1:0]};

`ifdef STBUF_FWD_EN
  stbuf_entry_t w_sel;
`endif

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    w_match = 1'b0;
`ifdef STBUF_FWD_EN
    w_sel   = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      if (((PW+1)'(k) < r_count) &&
          (r_mem[r_rd_ptr + PW'(k)].addr == ld_addr[AW-1:2])) begin
        w_match = 1'b1;
`ifdef STBUF_FWD_EN
        w_sel   = r_mem[r_rd_ptr + PW'(k)];
`endif
      end
    end
  end

`ifdef STBUF_FWD_EN
  assign ld_hit      = ld_valid && w_match && (w_sel.be == 4'b1111);
  assign ld_fwd      = ld_hit ? w_sel.data : '0;
  assign ld_conflict = ld_valid && w_match && (w_sel.be != 4'b1111);
`else
  assign ld_hit      = 1'b0;
  assign ld_fwd      = '0;
  assign ld_conflict = ld_valid && w_match;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: directed scenarios plus random traffic
// against a queue-based reference model; a separate monitor checks outputs.
module tb_store_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  typedef struct {
    logic        conf;
    logic        hit;
    logic [31:0] fwd;
  } ld_exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        st_err;
  logic        dm_we;
  logic [29:0] dm_addr;
  logic [31:0] dm_d;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_conflict;
  logic        ld_hit;
  logic [31:0] ld_fwd;
  logic        empty;

  int n_chk  = 0;
  int n_fail = 0;
  logic mon_on = 1'b0;

  ent_t    wr_q[$];
  logic    err_q[$];
  ld_exp_t ld_q[$];

  store_buffer #(.DEPTH(DEPTH), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_size(st_size), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready), .st_err(st_err),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_d(dm_d), .dm_be(dm_be), .dm_ack(dm_ack),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
    .ld_hit(ld_hit), .ld_fwd(ld_fwd), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic misaligned(input logic [1:0] sz, input logic [31:0] a);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      2'b10:   return a[1:0] != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic ent_t make_entry(input logic [1:0] sz, input logic [31:0] a,
                                      input logic [31:0] d);
    ent_t e;
    e.addr = a[31:2];
    case (sz)
      2'b00: begin e.be = 4'b0001 << a[1:0]; e.data = {4{d[7:0]}}; end
      2'b01: begin e.be = a[1] ? 4'b1100 : 4'b0011; e.data = {2{d[15:0]}}; end
      default: begin e.be = 4'b1111; e.data = d; end
    endcase
    return e;
  endfunction

  function automatic ld_exp_t model_load(input logic lv, input logic [31:0] la);
    ld_exp_t r;
    r = '{conf: 1'b0, hit: 1'b0, fwd: 32'h0};
    if (lv) begin
      for (int i = wr_q.size() - 1; i >= 0; i--) begin
        if (wr_q[i].addr == la[31:2]) begin
`ifdef STBUF_FWD_EN
          if (wr_q[i].be == 4'b1111) begin
            r.hit = 1'b1;
            r.fwd = wr_q[i].data;
          end else begin
            r.conf = 1'b1;
          end
`else
          r.conf = 1'b1;
`endif
          break;
        end
      end
    end
    return r;
  endfunction

  // Entered and left at posedge+1; one clock edge per call.
  task automatic cycle(input logic v, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input logic ack, input logic lv,
                       input logic [31:0] la, output logic acc);
    logic ready, mis, err_nxt;
    ready    = (wr_q.size() != DEPTH);
    mis      = misaligned(sz, a);
    acc      = v && ready && !mis;
    err_nxt  = v && ready && mis;
    st_valid = v;
    st_size  = sz;
    st_addr  = a;
    st_data  = d;
    dm_ack   = ack && (wr_q.size() != 0);
    ld_valid = lv;
    ld_addr  = la;
    ld_q.push_back(model_load(lv, la));
    @(posedge clk);
    #1;
    if (acc) wr_q.push_back(make_entry(sz, a, d));
    err_q.push_back(err_nxt);
  endtask

  task automatic idle_inputs();
    st_valid = 1'b0;
    st_size  = 2'b00;
    st_addr  = 32'h0;
    st_data  = 32'h0;
    dm_ack   = 1'b0;
    ld_valid = 1'b0;
    ld_addr  = 32'h0;
  endtask

  task automatic probe_ld(input logic [31:0] la, input logic exp_conf,
                          input logic exp_hit, input logic [31:0] exp_fwd);
    ld_valid = 1'b1;
    ld_addr  = la;
    #2;
    check("ld_conflict", ld_conflict, exp_conf);
    check("ld_hit", ld_hit, exp_hit);
    check("ld_fwd", ld_fwd, exp_fwd);
    ld_valid = 1'b0;
  endtask

  // Monitor: state outputs, error pulses, load outputs and drained writes.
  always @(negedge clk) begin
    if (mon_on && rst_n) begin
      logic    exp_err;
      ld_exp_t le;
      ent_t    e;
      check("empty", empty, wr_q.size() == 0);
      check("st_ready", st_ready, wr_q.size() != DEPTH);
      check("dm_we", dm_we, wr_q.size() != 0);
      exp_err = (err_q.size() != 0) ? err_q.pop_front() : 1'b0;
      check("st_err", st_err, exp_err);
      if (ld_q.size() != 0) begin
        le = ld_q.pop_front();
        check("mon_ld_conflict", ld_conflict, le.conf);
        check("mon_ld_hit", ld_hit, le.hit);
        check("mon_ld_fwd", ld_fwd, le.fwd);
      end
      if (dm_ack && dm_we) begin
        if (wr_q.size() == 0) begin
          check("drain_unexpected", 1'b1, 1'b0);
        end else begin
          e = wr_q.pop_front();
          check("drain_addr", dm_addr, e.addr);
          check("drain_data", dm_d, e.data);
          check("drain_be", dm_be, e.be);
        end
      end
    end
  end

  initial begin
    logic acc;
    int   tries;
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_dm_we", dm_we, 1'b0);
    check("rst_empty", empty, 1'b1);
    rst_n = 1'b1;
    #1;
    check("rst_st_ready", st_ready, 1'b1);
    check("rst_empty_rel", empty, 1'b1);
    check("rst_dm_we_rel", dm_we, 1'b0);
    check("rst_st_err", st_err, 1'b0);
    check("rst_ld_conflict", ld_conflict, 1'b0);
    check("rst_ld_hit", ld_hit, 1'b0);
    check("rst_dm_bus", {dm_addr, dm_d, dm_be}, 66'h0);
    @(posedge clk);
    #1;
    mon_on = 1'b1;

    // Byte store to 0x103 lands in lane 3.
    cycle(1'b1, 2'b00, 32'h103, 32'hAB, 1'b0, 1'b0, 32'h0, acc);
    check("sb_dm_we", dm_we, 1'b1);
    check("sb_dm_addr", dm_addr, 30'h40);
    check("sb_dm_be", dm_be, 4'b1000);
    check("sb_dm_d", dm_d, 32'hABABABAB);
    cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, acc);
    check("sb_empty_after_ack", empty, 1'b1);

    // Fill with four words, the fifth waits for the first ack.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 2'b10, 32'h300 + 32'(4 * i), 32'h1000_0000 + 32'(i), 1'b0,
            1'b0, 32'h0, acc);
    end
    check("fill_ready_low", st_ready, 1'b0);
    cycle(1'b1, 2'b10, 32'h310, 32'h1000_0004, 1'b1, 1'b0, 32'h0, acc);
    check("fill_ready_after_ack", st_ready, 1'b1);
    tries = 0;
    do begin
      cycle(1'b1, 2'b10, 32'h310, 32'h1000_0004, 1'b1, 1'b0, 32'h0, acc);
      tries++;
    end while (!acc && tries < 8);
    for (int i = 0; i < 10 && wr_q.size() != 0; i++) begin
      cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, acc);
    end
    check("fill_drained", empty, 1'b1);

    // Misaligned halfword and word both rejected.
    cycle(1'b1, 2'b01, 32'h101, 32'h1234, 1'b0, 1'b0, 32'h0, acc);
    check("mis_sh_err", st_err, 1'b1);
    cycle(1'b1, 2'b10, 32'h102, 32'h5678, 1'b0, 1'b0, 32'h0, acc);
    check("mis_sw_err", st_err, 1'b1);
    cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, acc);
    check("mis_err_clear", st_err, 1'b0);
    check("mis_count_zero", empty, 1'b1);

    // Forwarding / conflict.
    cycle(1'b1, 2'b10, 32'h200, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, acc);
    cycle(1'b1, 2'b00, 32'h204, 32'h55, 1'b0, 1'b0, 32'h0, acc);
    st_valid = 1'b0;
`ifdef STBUF_FWD_EN
    probe_ld(32'h200, 1'b0, 1'b1, 32'hDEADBEEF);
`else
    probe_ld(32'h200, 1'b1, 1'b0, 32'h0);
`endif
    probe_ld(32'h204, 1'b1, 1'b0, 32'h0);
    probe_ld(32'h208, 1'b0, 1'b0, 32'h0);

    // Reset while three entries are draining.
    cycle(1'b1, 2'b10, 32'h20C, 32'h0BADF00D, 1'b0, 1'b0, 32'h0, acc);
    st_valid = 1'b0;
    dm_ack   = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("rstmid_dm_we", dm_we, 1'b0);
    check("rstmid_empty", empty, 1'b1);
    idle_inputs();
    wr_q.delete();
    err_q.delete();
    ld_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid_empty_rel", empty, 1'b1);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      logic [1:0]  sz;
      logic [31:0] a, d, la;
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = 32'h200 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b10) a[1:0] = 2'b00;
        if (sz == 2'b01) a[0]   = 1'b0;
      end
      d  = $urandom;
      la = 32'h200 + 32'($urandom_range(0, 31));
      cycle($urandom_range(0, 3) != 0, sz, a, d, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, la, acc);
    end
    for (int i = 0; i < 12 && wr_q.size() != 0; i++) begin
      cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, acc);
    end
    cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, acc);
    check("final_empty", empty, 1'b1);
    check("final_dm_we", dm_we, 1'b0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-store buffer between the execute stage and the data-memory write port. It accepts byte, halfword and word stores from the pipeline and aligns each store into a 32-bit lane with byte enables. Accepted stores queue in a small in-order FIFO and drain to data memory through a valid/ack handshake, so the pipeline does not stall on memory write latency. It is the write-side counterpart of the load/writeback path that consumes `dm_q`.

## Interface
- `DEPTH`, 4: number of buffered stores; a power of two, at least 2.
- `AW`, 32: byte-address width.
- `N`: data width, taken from `the_pkg` (32). Not a module parameter.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `st_valid` in 1: store request.
- `st_size` in 2: encoded as `SZ_B`=00, `SZ_H`=01, `SZ_W`=10; 11 is reserved.
- `st_addr` in AW: byte address.
- `st_data` in N: store data, right-justified.
- `st_ready` out 1: buffer can accept a store.
- `st_err` out 1: one-cycle pulse flagging a misaligned or reserved-size store.
- `dm_we` out 1: head entry valid toward memory.
- `dm_addr` out AW-2: word address.
- `dm_d` out N: lane-aligned write data.
- `dm_be` out 4: byte enables.
- `dm_ack` in 1: memory accepted the head entry this cycle.
- `ld_valid` in 1: a load is in execute.
- `ld_addr` in AW: byte address of that load.
- `ld_conflict` out 1: the load must stall.
- `ld_hit` out 1: forwarded data is valid (only with `STBUF_FWD_EN`).
- `ld_fwd` out N: forwarded word (only with `STBUF_FWD_EN`).
- `empty` out 1: no stores are buffered.

## Operation
- **Accept:** a store is accepted on an edge where `st_valid && st_ready` and the store is aligned.
- **Alignment check:**
  - Byte stores are always aligned.
  - Halfword stores require `st_addr[0]=0`.
  - Word stores require `st_addr[1:0]=0`.
  - Size 11 is always an error.
- **Error:** a failing store is not enqueued. `st_err` pulses high in the next cycle. Pointers do not change.
- **Lane alignment:**
  - Byte: `dm_be = 4'b0001 << addr[1:0]`; `dm_d` replicates `st_data[7:0]` into all four lanes.
  - Halfword: `dm_be` = 0011 if `addr[1]=0`, else 1100; `dm_d` replicates `st_data[15:0]`.
  - Word: `dm_be` = 1111; `dm_d` = `st_data`.
- **Drain:** the head entry is presented on `dm_we/dm_addr/dm_d/dm_be` while the buffer is not empty. The head is dequeued on an edge where `dm_ack` is high. The memory side must hold `dm_ack` low while `dm_we` is low; an ack with no valid head is ignored.
- **FIFO control:**
  - `st_ready = (count != DEPTH)`.
  - Enqueue and dequeue in the same cycle leave `count` unchanged.
  - When full, `st_ready` stays low even if `dm_ack` is high in that cycle. There is no same-cycle bypass.
- **Pointer wrap:** read and write pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. `count` is `$clog2(DEPTH)+1` bits.
- **Load conflict:** `ld_conflict = ld_valid` AND some valid entry has `dm_addr == ld_addr[AW-1:2]`. This is combinational.
- **Store order:** memory writes complete strictly in acceptance order.

## Timing
- **Reset values:** `count`=0, pointers 0, `st_ready`=1, `empty`=1, `dm_we`=0, `st_err`=0, `ld_conflict`=0, `ld_hit`=0. `dm_d`, `dm_addr`, `dm_be` = 0.
- **Reset mid-drain:** asserting `rst_n` low while draining discards all entries immediately (asynchronous). `dm_we` drops without waiting for `dm_ack`.
- **Latency:** a store accepted at edge k appears on `dm_we` in cycle k+1 if the buffer was empty before it.
- **Throughput:** one store in and one store out per cycle.
- **Timing of derived outputs:**
  - `st_ready`, `empty` and `dm_*` are registered-state derived; they carry no combinational path from `st_*` or `dm_ack`.
  - `ld_conflict`, `ld_hit` and `ld_fwd` are combinational from `ld_*` and buffer state.

## Configuration
- `STBUF_FWD_EN` defined:
  - The youngest matching entry is selected.
  - If that entry has `dm_be`=1111, `ld_hit`=1, `ld_fwd` = its data, and `ld_conflict`=0.
  - If that entry is a partial store, `ld_hit`=0 and `ld_conflict`=1.
- `STBUF_FWD_EN` undefined:
  - `ld_hit` and `ld_fwd` are tied to 0.
  - Any match raises `ld_conflict`.

## Structure
- `the_pkg` gains:
  - the `SZ_B`/`SZ_H`/`SZ_W` localparams;
  - a packed struct `stbuf_entry_t` with fields `addr[AW-2]`, `data[N]`, `be[4]`.
- One sub-module, `store_align`. It is combinational: size, address and data in; `be`, lane data and `misaligned` out.
- The FIFO storage, pointer logic and match/forward logic stay in `store_buffer`.

## Test plan
- **Reset:** hold `rst_n` low, then release → `st_ready`=1, `empty`=1, `dm_we`=0.
- **Byte store:** SB to 0x103 with data 0xAB → next cycle `dm_addr`=0x40, `dm_be`=1000, `dm_d`=0xABABABAB. Holding `dm_ack`=1 → `empty`=1 one cycle later.
- **Fill and ordering:** five SW stores back-to-back with `dm_ack`=0 → `st_ready` falls after the 4th. Releasing `dm_ack` drains the four entries in order; the 5th store is accepted after the first ack.
- **Misalignment:** SH to 0x101, then SW to 0x102 → `st_err` pulses on each; `count` stays 0.
- **Forwarding:** buffer holds SW 0x200=0xDEADBEEF and SB 0x204. A load from 0x200 → `ld_hit`=1 and `ld_fwd`=0xDEADBEEF with the macro; `ld_conflict`=1 without it. A load from 0x204 → `ld_conflict`=1 in both builds.
- **Reset mid-drain:** with 3 entries, assert `rst_n` low → `dm_we`=0 immediately; after release, `empty`=1.
